uart_tx_feeder: RTL and testbench

Upstream stage of the UART transmitter. It buffers bytes written by the host in a synchronous FIFO and launches one frame at a time into the TX FSM/datapath. For each frame it drives a single-cycle tx_start, holds tx_data stable, and waits for the transmitter's tx_done before launching the next byte. An optional guard gap can be inserted between frames.

---
 rtl/uart_tx_feeder.sv | 100 ++++++++++
 tb/tb_uart_tx_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered launcher that feeds one byte per frame to a UART TX FSM.
//   clk, rst              : clock, synchronous active-high reset
//   wr_en, wr_data        : host byte write (dropped when full)
//   tx_en                 : allows a new frame to start
//   tx_done               : end-of-frame pulse from the transmitter
//   ovf_clr               : clears the sticky overflow flag
//   tx_start, tx_data     : one-cycle launch pulse and the byte held for the frame
//   busy                  : high from launch through the end of the guard gap
//   full, empty, count    : FIFO occupancy (registered)
//   overflow              : sticky dropped-write flag
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              tx_en,
    input  logic              tx_done,
    input  logic              ovf_clr,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    state_t state, state_nx;
    logic [7:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [ADDR_W:0] count_nx;
    logic push, pop, drop;
    // full is never bypassed by a same-cycle pop: the write is judged on the held count
    assign push = wr_en && !full;
    assign drop = wr_en && full;
    assign pop  = (state == IDLE) && tx_en && !empty;
    assign count_nx = (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        tx_start = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: state_nx = pop ? LAUNCH : IDLE;
            LAUNCH: begin
                tx_start = 1'b1;
                busy     = 1'b1;
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy = 1'b1;
                if (tx_done) begin
                    state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
                    gap_nx   = GW'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                busy     = 1'b1;
                gap_nx   = gap_cnt - 1'b1;
                state_nx = (gap_cnt == '0) ? IDLE : GAP;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            gap_cnt  <= gap_nx;
            count    <= count_nx;
            full     <= count_nx == FULL_CNT;
            empty    <= count_nx == '0;
            overflow <= drop || (overflow && !ovf_clr);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed table and sequence checks for uart_tx_feeder.
module tb_uart_tx_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0, tx_en = 1'b0, tx_done = 1'b0, ovf_clr = 1'b0;
    logic [7:0] wr_data = '0;
    logic tx_start, busy, full, empty, overflow;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic s3, b3, f3, e3, o3;
    logic [7:0] d3;
    logic [4:0] c3;
    int n_chk = 0, n_pass = 0, n_launch = 0, max_count = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CYCLES(0)) g0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_en(tx_en),
        .tx_done(tx_done), .ovf_clr(ovf_clr), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .full(full), .empty(empty), .count(count), .overflow(overflow));

    uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CYCLES(3)) g3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_en(tx_en),
        .tx_done(tx_done), .ovf_clr(ovf_clr), .tx_start(s3), .tx_data(d3),
        .busy(b3), .full(f3), .empty(e3), .count(c3), .overflow(o3));

    always @(posedge clk) if (tx_start === 1'b1) n_launch <= n_launch + 1;

    typedef struct {
        logic wr_en; logic [7:0] wr_data; logic tx_en, tx_done, ovf_clr; int reps;
        logic e_start, e_busy, e_empty, e_full; logic [4:0] e_count; logic [7:0] e_data; logic e_ovf;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 0; tx_en = 0; tx_done = 0; ovf_clr = 0; wr_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wr_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; wr_data = first + 8'(i);
            cyc();
        end
        wr_en = 1'b0;
    endtask

    task automatic serve(input int delay);
        int n = 0;
        logic [7:0] e;
        while (busy !== 1'b1 && n < 40) begin cyc(); n++; end
        chk("launch_seen", busy, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("launch_data", tx_data, e);
        repeat (delay) cyc();
        tx_done = 1'b1; cyc(); tx_done = 1'b0;
    endtask

    initial begin
        int l0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l0;
        vt[0]  = '{0, 8'h00, 0, 0, 0, 1,  0, 0, 1, 0, 5'd0, 8'h00, 0};
        vt[1]  = '{1, 8'hA5, 1, 0, 0, 1,  0, 0, 0, 0, 5'd1, 8'h00, 0};
        vt[2]  = '{0, 8'h00, 1, 0, 0, 1,  1, 1, 1, 0, 5'd0, 8'hA5, 0};
        vt[3]  = '{0, 8'h00, 1, 0, 0, 18, 0, 1, 1, 0, 5'd0, 8'hA5, 0};
        vt[4]  = '{0, 8'h00, 1, 1, 0, 1,  0, 0, 1, 0, 5'd0, 8'hA5, 0};
        vt[5]  = '{0, 8'h00, 1, 0, 0, 3,  0, 0, 1, 0, 5'd0, 8'hA5, 0};
        vt[6]  = '{1, 8'h3C, 0, 0, 0, 1,  0, 0, 0, 0, 5'd1, 8'hA5, 0};
        vt[7]  = '{0, 8'h00, 0, 0, 0, 2,  0, 0, 0, 0, 5'd1, 8'hA5, 0};
        vt[8]  = '{0, 8'h00, 1, 0, 0, 1,  1, 1, 1, 0, 5'd0, 8'h3C, 0};
        vt[9]  = '{0, 8'h00, 1, 1, 0, 1,  0, 1, 1, 0, 5'd0, 8'h3C, 0};
        vt[10] = '{0, 8'h00, 1, 0, 0, 2,  0, 1, 1, 0, 5'd0, 8'h3C, 0};
        vt[11] = '{0, 8'h00, 1, 1, 0, 1,  0, 0, 1, 0, 5'd0, 8'h3C, 0};

        do_reset();
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < vt[r].reps; k++) begin
                wr_en = vt[r].wr_en; wr_data = vt[r].wr_data; tx_en = vt[r].tx_en;
                tx_done = vt[r].tx_done; ovf_clr = vt[r].ovf_clr;
                cyc();
                chk($sformatf("row%0d tx_start", r), tx_start, vt[r].e_start);
                chk($sformatf("row%0d busy", r), busy, vt[r].e_busy);
                chk($sformatf("row%0d empty", r), empty, vt[r].e_empty);
                chk($sformatf("row%0d full", r), full, vt[r].e_full);
                chk($sformatf("row%0d count", r), count, vt[r].e_count);
                chk($sformatf("row%0d tx_data", r), tx_data, vt[r].e_data);
                chk($sformatf("row%0d overflow", r), overflow, vt[r].e_ovf);
            end
        end
        wr_en = 0; tx_done = 0;

        // ordering across pointer wrap
        do_reset();
        tx_en = 1'b1; max_count = 0; l0 = n_launch;
        for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
        wr_burst(8'h00, 12);
        repeat (6) serve(3);
        wr_burst(8'h0C, 8);
        repeat (14) serve(2);
        repeat (3) cyc();
        chk("order_launches", n_launch - l0, 20);
        chk("order_overflow", overflow, 0);
        chk("order_empty", empty, 1);
        chk("order_max_count_le16", max_count <= 16, 1);

        // overflow, clear priority, and full-with-pop drop
        do_reset();
        wr_burst(8'h10, 17);
        chk("ovf_full", full, 1);
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; cyc();
        chk("ovf_set_wins", overflow, 1);
        wr_en = 1'b0; cyc(); ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
        tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'h55; cyc(); wr_en = 1'b0;
        chk("sim_full_count", count, 15);
        chk("sim_full_ovf", overflow, 1);
        chk("sim_full_start", tx_start, 1);
        repeat (16) serve(2);
        repeat (2) cyc();
        chk("ovf_drained_empty", empty, 1);

        // write and pop together at count 5
        do_reset();
        wr_burst(8'h60, 5);
        chk("c5_count_before", count, 5);
        tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'h65; cyc(); wr_en = 1'b0;
        chk("c5_count_after", count, 5);
        chk("c5_start", tx_start, 1);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h60 + 8'(i));
        repeat (6) serve(1);

        // guard gap on the GAP_CYCLES=3 instance
        do_reset();
        tx_en = 1'b1;
        wr_burst(8'hB1, 2);
        chk("gap_first_start", s3, 1);
        chk("gap_first_data", d3, 8'hB1);
        repeat (3) cyc();
        tx_done = 1'b1; cyc(); tx_done = 1'b0;
        chk("gap_busy_in_gap", b3, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("gap_start_at_%0d", i), s3, logic'(i == 4));
            if (i == 3) chk("gap_idle_busy", b3, 0);
        end
        chk("gap_second_data", d3, 8'hB2);

        // tx_en dropped mid-frame
        do_reset();
        tx_en = 1'b1;
        wr_burst(8'hC1, 2);
        tx_en = 1'b0; cyc(); cyc();
        tx_done = 1'b1; cyc(); tx_done = 1'b0;
        chk("en_frame_done_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("en_blocked_start", tx_start, 0);
            chk("en_blocked_count", count, 1);
        end
        tx_en = 1'b1; cyc();
        chk("en_resume_start", tx_start, 1);
        chk("en_resume_data", tx_data, 8'hC2);
        cyc(); tx_done = 1'b1; cyc(); tx_done = 1'b0;

        // reset during WAIT_DONE
        do_reset();
        tx_en = 1'b1;
        wr_burst(8'hD0, 4);
        cyc();
        chk("rst_pre_count", count, 3);
        chk("rst_pre_busy", busy, 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        l0 = n_launch;
        tx_done = 1'b1; cyc(); tx_done = 1'b0;
        repeat (3) begin
            cyc();
            chk("rst_no_start", tx_start, 0);
            chk("rst_no_busy", busy, 0);
        end
        chk("rst_no_launch", n_launch - l0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
